// File: rtl/ir_cmd_controller.sv
// IR command sequencer: separates new key presses from held-key repeats, times
// auto-repeat and release on a divided tick, and queues events behind valid/ack.
module ir_cmd_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int HOLD_TICKS   = 120,
  parameter int REPEAT_TICKS = 250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ir_cmd,
  input  logic       ir_cmd_ready,
  output logic [7:0] cmd_data,
  output logic       cmd_repeat,
  output logic       cmd_valid,
  input  logic       cmd_ack,
  output logic       key_held,
  output logic       overflow
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  typedef struct packed {
    logic       rpt;
    logic [7:0] code;
  } event_t;

  // ---------------------------------------------------------------------------
  // Free-running timebase, independent of enable
  // ---------------------------------------------------------------------------
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of the others regardless of block order.
  always_ff @(posedge clk) begin
    if (reset || w_tick) r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Key tracking FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_key;
  logic [7:0]    w_key_nxt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic [HW-1:0] w_hold_inc;
  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_nxt;
  logic [RW-1:0] w_rep_inc;
  logic          w_push;
  event_t        w_push_evt;

  assign w_hold_inc = r_hold_cnt + 1'b1;
  assign w_rep_inc  = r_rep_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_key      <= w_key_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the branches below can leave it holding its old value (no inferred latch).
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_push      = 1'b0;
    w_push_evt  = '{rpt: 1'b0, code: ir_cmd};

    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = '0;
      w_rep_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ir_cmd_ready) begin
            w_push      = 1'b1;
            w_key_nxt   = ir_cmd;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
            w_state_nxt = S_HELD;
          end
        end

        S_HELD: begin
          if (ir_cmd_ready && (ir_cmd != r_key)) begin
            // A different key restarts both timers and suppresses any repeat due now.
            w_push     = 1'b1;
            w_key_nxt  = ir_cmd;
            w_hold_nxt = '0;
            w_rep_nxt  = '0;
          end else begin
            if (ir_cmd_ready) begin
              w_hold_nxt = '0;
            end else if (w_tick) begin
              if (w_hold_inc == HW'(HOLD_TICKS)) begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
              end else begin
                w_hold_nxt = w_hold_inc;
              end
            end

            if (w_tick) begin
              if (w_rep_inc == RW'(REPEAT_TICKS)) begin
                w_push     = 1'b1;
                w_push_evt = '{rpt: 1'b1, code: r_key};
                w_rep_nxt  = '0;
              end else begin
                w_rep_nxt = w_rep_inc;
              end
            end
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event queue: pointers carry one extra wrap bit to tell full from empty
  // ---------------------------------------------------------------------------
  event_t      r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_overflow;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_wr_en;
  event_t      w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = cmd_ack && !w_empty;
  assign w_wr_en = w_push && (!w_full || w_pop);

  // NOTE: the storage array is deliberately not reset; the empty flag gates the
  // outputs, so stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_push_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow <= w_push && w_full && !w_pop;
    end
  end

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign cmd_valid  = !w_empty;
  assign cmd_data   = w_empty ? 8'h00 : w_head.code;
  assign cmd_repeat = w_empty ? 1'b0  : w_head.rpt;
  assign key_held   = (r_state == S_HELD);
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ir_cmd_controller.sv
// Self-checking bench for ir_cmd_controller: scenario tasks drive strobes and
// check timing inline; a forked monitor scores every popped event against a queue.
module tb_ir_cmd_controller;

  localparam int TICK_DIV     = 4;
  localparam int HOLD_TICKS   = 3;
  localparam int REPEAT_TICKS = 5;
  localparam int FIFO_DEPTH   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] ir_cmd;
  logic       ir_cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_repeat;
  logic       cmd_valid;
  logic       cmd_ack;
  logic       key_held;
  logic       overflow;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_ovf    = 0;
  int         cyc      = 0;
  logic [8:0] sb[$];  // expected {repeat, code} in pop order

  always #5 clk = ~clk;

  // Tick phase reference: the tick fires in cycles where cyc % TICK_DIV == TICK_DIV-1.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  ir_cmd_controller #(
    .TICK_DIV    (TICK_DIV),
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ir_cmd      (ir_cmd),
    .ir_cmd_ready(ir_cmd_ready),
    .cmd_data    (cmd_data),
    .cmd_repeat  (cmd_repeat),
    .cmd_valid   (cmd_valid),
    .cmd_ack     (cmd_ack),
    .key_held    (key_held),
    .overflow    (overflow)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic align(input int ph);
    ir_cmd_ready = 1'b0;
    next_cycle();
    while (cyc % TICK_DIV != ph) next_cycle();
  endtask

  task automatic wait_idle();
    int k = 0;
    ir_cmd_ready = 1'b0;
    while (key_held !== 1'b0 && k < 64) begin
      next_cycle();
      k++;
    end
    n_checks++;
    if (key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: key_held=%b after %0d cycles, expected 0", key_held, k);
    end
  endtask

  task automatic monitor();
    logic [8:0] exp_evt;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (overflow === 1'b1) n_ovf++;
        if (cmd_valid === 1'b1 && cmd_ack === 1'b1) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got rpt=%b code=%h, expected no event",
                     cmd_repeat, cmd_data);
          end else begin
            exp_evt = sb.pop_front();
            if ({cmd_repeat, cmd_data} !== exp_evt) begin
              n_fail++;
              $display("FAIL event_order: got rpt=%b code=%h, expected rpt=%b code=%h",
                       cmd_repeat, cmd_data, exp_evt[8], exp_evt[7:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; cmd_ack = 1'b0;
    ir_cmd = 8'h5A; ir_cmd_ready = 1'b1;
    repeat (3) next_cycle();
    n_checks++;
    if ({cmd_valid, cmd_repeat, cmd_data, key_held, overflow} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 000",
               {cmd_valid, cmd_repeat, cmd_data, key_held, overflow});
    end
    reset = 1'b0; ir_cmd_ready = 1'b0;
    next_cycle();
    n_checks++;
    if ({cmd_valid, key_held} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: valid/held=%b, expected 00", {cmd_valid, key_held});
    end
  endtask

  task automatic test_single();
    wait_idle(); enable = 1'b1; cmd_ack = 1'b1;
    align(0);
    for (int t = 0; t <= 32; t++) begin
      ir_cmd = 8'h45;
      ir_cmd_ready = (t == 0);
      if (t == 0) sb.push_back({1'b0, 8'h45});
      if (t == 1) begin
        n_checks++;
        if ({cmd_valid, cmd_repeat, cmd_data, key_held} !== {1'b1, 1'b0, 8'h45, 1'b1}) begin
          n_fail++;
          $display("FAIL single_latency: v/r/d/h=%b/%b/%h/%b, expected 1/0/45/1",
                   cmd_valid, cmd_repeat, cmd_data, key_held);
        end
      end
      if (t == 11 || t == 12) begin
        n_checks++;
        if (key_held !== (t == 11)) begin
          n_fail++;
          $display("FAIL single_release_t%0d: key_held=%b, expected %b", t, key_held, t == 11);
        end
      end
      if (t == 32) begin
        n_checks++;
        if (cmd_valid !== 1'b0 || sb.size() != 0) begin
          n_fail++;
          $display("FAIL single_drain: valid=%b pending=%0d, expected 0/0", cmd_valid, sb.size());
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_repeat();
    wait_idle(); enable = 1'b1; cmd_ack = 1'b1;
    align(0);
    for (int t = 0; t <= 52; t++) begin
      ir_cmd = 8'h45;
      ir_cmd_ready = (t % 8 == 0) && (t <= 40);
      if (t == 0) sb.push_back({1'b0, 8'h45});
      if (t == 19 || t == 39) sb.push_back({1'b1, 8'h45});
      if (t == 20 || t == 40) begin
        n_checks++;
        if ({cmd_valid, cmd_repeat, cmd_data} !== {1'b1, 1'b1, 8'h45}) begin
          n_fail++;
          $display("FAIL repeat_event_t%0d: v/r/d=%b/%b/%h, expected 1/1/45",
                   t, cmd_valid, cmd_repeat, cmd_data);
        end
      end
      if (t == 51 || t == 52) begin
        n_checks++;
        if (key_held !== (t == 51)) begin
          n_fail++;
          $display("FAIL repeat_release_t%0d: key_held=%b, expected %b", t, key_held, t == 51);
        end
      end
      if (t == 52) begin
        n_checks++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL repeat_count: %0d expected events not seen, expected 0", sb.size());
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_new_key();
    wait_idle(); enable = 1'b1; cmd_ack = 1'b1;
    align(2);
    for (int t = 0; t <= 31; t++) begin
      ir_cmd = (t == 0) ? 8'h45 : 8'h46;
      ir_cmd_ready = (t == 0 || t == 2 || t == 10 || t == 18);
      if (t == 0) sb.push_back({1'b0, 8'h45});
      if (t == 2) sb.push_back({1'b0, 8'h46});
      if (t == 21) sb.push_back({1'b1, 8'h46});
      if (t == 1 || t == 3) begin
        n_checks++;
        if ({cmd_valid, cmd_repeat, cmd_data} !== {1'b1, 1'b0, (t == 1) ? 8'h45 : 8'h46}) begin
          n_fail++;
          $display("FAIL newkey_press_t%0d: v/r/d=%b/%b/%h, expected 1/0/%h",
                   t, cmd_valid, cmd_repeat, cmd_data, (t == 1) ? 8'h45 : 8'h46);
        end
      end
      if (t == 18) begin
        n_checks++;
        if (cmd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL newkey_rep_restart: valid=%b, expected 0 (repeat too early)", cmd_valid);
        end
      end
      if (t == 22) begin
        n_checks++;
        if ({cmd_valid, cmd_repeat, cmd_data} !== {1'b1, 1'b1, 8'h46}) begin
          n_fail++;
          $display("FAIL newkey_repeat: v/r/d=%b/%b/%h, expected 1/1/46",
                   cmd_valid, cmd_repeat, cmd_data);
        end
      end
      if (t == 29 || t == 30) begin
        n_checks++;
        if (key_held !== (t == 29)) begin
          n_fail++;
          $display("FAIL newkey_release_t%0d: key_held=%b, expected %b", t, key_held, t == 29);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_overflow();
    logic [7:0] code;
    wait_idle(); enable = 1'b1; cmd_ack = 1'b0;
    align(0);
    n_ovf = 0;
    for (int t = 0; t <= 12; t++) begin
      code = 8'hA1 + 8'(t);
      ir_cmd = code;
      ir_cmd_ready = (t <= 4);
      if (t <= 3) sb.push_back({1'b0, code});
      if (t == 5 || t == 8) begin
        n_checks++;
        if ({cmd_valid, cmd_repeat, cmd_data} !== {1'b1, 1'b0, 8'hA1}) begin
          n_fail++;
          $display("FAIL overflow_head_t%0d: v/r/d=%b/%b/%h, expected 1/0/a1",
                   t, cmd_valid, cmd_repeat, cmd_data);
        end
      end
      if (t == 8) begin
        n_checks++;
        if (n_ovf != 1) begin
          n_fail++;
          $display("FAIL overflow_pulses: got %0d, expected 1", n_ovf);
        end
      end
      if (t == 12) begin
        n_checks++;
        if (cmd_valid !== 1'b0 || sb.size() != 0) begin
          n_fail++;
          $display("FAIL back_to_back_drain: valid=%b pending=%0d, expected 0/0",
                   cmd_valid, sb.size());
        end
      end
      cmd_ack = (t >= 8 && t <= 11);
      next_cycle();
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_full_ack();
    logic [7:0] code;
    wait_idle(); enable = 1'b1; cmd_ack = 1'b0;
    align(0);
    n_ovf = 0;
    for (int t = 0; t <= 10; t++) begin
      code = (t == 5) ? 8'hB5 : 8'hB1 + 8'(t);
      ir_cmd = code;
      ir_cmd_ready = (t <= 3 || t == 5);
      if (t <= 3 || t == 5) sb.push_back({1'b0, code});
      if (t == 4 || t == 6) begin
        n_checks++;
        if ({cmd_valid, cmd_data} !== {1'b1, (t == 4) ? 8'hB1 : 8'hB2}) begin
          n_fail++;
          $display("FAIL full_ack_head_t%0d: v/d=%b/%h, expected 1/%h",
                   t, cmd_valid, cmd_data, (t == 4) ? 8'hB1 : 8'hB2);
        end
      end
      if (t == 10) begin
        n_checks++;
        if (n_ovf != 0 || cmd_valid !== 1'b0 || sb.size() != 0) begin
          n_fail++;
          $display("FAIL full_ack_result: ovf=%0d valid=%b pending=%0d, expected 0/0/0",
                   n_ovf, cmd_valid, sb.size());
        end
      end
      cmd_ack = (t >= 5 && t <= 9);
      next_cycle();
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_enable();
    wait_idle(); enable = 1'b1; cmd_ack = 1'b0;
    next_cycle();
    for (int t = 0; t <= 15; t++) begin
      enable = !(t >= 2 && t <= 10);
      ir_cmd = (t == 0) ? 8'hC1 : (t == 4) ? 8'hC3 : 8'hC2;
      ir_cmd_ready = (t == 0 || t == 1 || t == 4 || t == 12);
      if (t == 0) sb.push_back({1'b0, 8'hC1});
      if (t == 1 || t == 12) sb.push_back({1'b0, 8'hC2});
      if (t == 2 || t == 3) begin
        n_checks++;
        if (key_held !== (t == 2)) begin
          n_fail++;
          $display("FAIL enable_held_t%0d: key_held=%b, expected %b", t, key_held, t == 2);
        end
      end
      if (t == 5) begin
        n_checks++;
        if ({cmd_valid, cmd_data, key_held} !== {1'b1, 8'hC1, 1'b0}) begin
          n_fail++;
          $display("FAIL enable_ignore: v/d/h=%b/%h/%b, expected 1/c1/0",
                   cmd_valid, cmd_data, key_held);
        end
      end
      if (t == 8 || t == 10) begin
        n_checks++;
        if (cmd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL enable_drain_t%0d: valid=%b, expected 0", t, cmd_valid);
        end
      end
      if (t == 13) begin
        n_checks++;
        if ({cmd_valid, cmd_repeat, cmd_data, key_held} !== {1'b1, 1'b0, 8'hC2, 1'b1}) begin
          n_fail++;
          $display("FAIL enable_reenter: v/r/d/h=%b/%b/%h/%b, expected 1/0/c2/1",
                   cmd_valid, cmd_repeat, cmd_data, key_held);
        end
      end
      if (t == 15) begin
        n_checks++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL enable_pending: %0d expected events not seen, expected 0", sb.size());
        end
      end
      cmd_ack = (t == 6 || t == 7 || t >= 13);
      next_cycle();
    end
    cmd_ack = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    wait_idle(); enable = 1'b1; cmd_ack = 1'b0;
    next_cycle();
    for (int t = 0; t <= 6; t++) begin
      ir_cmd = (t == 0) ? 8'hE1 : 8'hE2;
      ir_cmd_ready = (t <= 1);
      reset = (t == 2);
      if (t == 2) begin
        n_checks++;
        if ({cmd_valid, key_held} !== 2'b11) begin
          n_fail++;
          $display("FAIL reset_mid_pre: valid/held=%b, expected 11", {cmd_valid, key_held});
        end
      end
      if (t == 3) begin
        n_checks++;
        if ({cmd_valid, cmd_repeat, cmd_data, key_held, overflow} !== 12'h000) begin
          n_fail++;
          $display("FAIL reset_mid_clear: got %h, expected 000",
                   {cmd_valid, cmd_repeat, cmd_data, key_held, overflow});
        end
      end
      if (t == 6) begin
        n_checks++;
        if ({cmd_valid, key_held} !== 2'b00) begin
          n_fail++;
          $display("FAIL reset_mid_after: valid/held=%b, expected 00", {cmd_valid, key_held});
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_repeat();
    test_new_key();
    test_overflow();
    test_full_ack();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_cmd_controller.md
# ir_cmd_controller

Command sequencer between `ir_receiver` and the application logic. It takes the one-cycle `ir_cmd_ready` strobes, separates new key presses from held-key repeats, and generates auto-repeat events while a key is held. Events queue in a small FIFO and leave on a valid/ack handshake, so slow consumers (display, motor control) never lose a keypress.

## Interface
- `TICK_DIV`, 50000: clk cycles per time tick (1 ms at 50 MHz); ≥2
- `HOLD_TICKS`, 120: ticks without a matching strobe before the held key counts as released; ≥2
- `REPEAT_TICKS`, 250: tick interval between auto-repeat events while held; ≥2
- `FIFO_DEPTH`, 4: event queue depth; power of 2, ≥2

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  1 = accept strobes; 0 = ignore strobes and force IDLE
- `ir_cmd`  in  8  code from receiver; sampled only when `ir_cmd_ready`=1
- `ir_cmd_ready`  in  1  one-cycle strobe: code received
- `cmd_data`  out  8  head-of-queue code
- `cmd_repeat`  out  1  head event flag: 0 = new press, 1 = auto-repeat
- `cmd_valid`  out  1  queue non-empty
- `cmd_ack`  in  1  consumer accepts head (pop when `cmd_valid`&`cmd_ack`)
- `key_held`  out  1  1 while state = HELD
- `overflow`  out  1  one-cycle pulse: event dropped, queue full

## Operation
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. `tick` is 1 in the cycle where count = TICK_DIV-1. It is free-running and independent of `enable`.
- State IDLE:
  - On `ir_cmd_ready` with `enable`: push {0,`ir_cmd`}, latch `key`=`ir_cmd`, clear `hold_cnt` and `rep_cnt`, go to HELD.
- State HELD:
  - Strobe with `ir_cmd`=`key`: clear `hold_cnt`. No push.
  - Strobe with `ir_cmd`≠`key`: push {0,`ir_cmd`}, latch the new `key`, clear both counters, stay in HELD.
  - On `tick` (no strobe this cycle): `hold_cnt`+1. If the incremented value = HOLD_TICKS, go to IDLE. No event is generated on release.
  - On `tick`: `rep_cnt`+1. If it reaches REPEAT_TICKS, push {1,`key`} and clear `rep_cnt`.
  - If a strobe and a `tick` arrive in the same cycle, the strobe wins for `hold_cnt`: it is cleared and no release occurs. `rep_cnt` still advances unless the strobe carries a different key.
  - If release and repeat expiry happen on the same `tick`, the repeat push happens and the state still goes to IDLE.
- `enable`=0: state goes to IDLE next cycle and counters clear. The queue is kept and keeps draining.
- Counter widths: `$clog2(param+1)` each. Counters never exceed their parameter.
- FIFO:
  - Rd/wr pointers with one extra wrap bit.
  - Full: pointers differ only in the MSB. Empty: pointers equal.
  - Push when full: the event is dropped and `overflow`=1 for that cycle. The exception is a same-cycle pop, in which case both operations succeed.
  - Pop when empty is ignored.
  - Only one push source per cycle. A new-key push takes priority over a same-cycle repeat push, and the repeat push is discarded silently.

## Timing
- Reset values: state IDLE, counters 0, pointers 0, `cmd_valid`=0, `cmd_data`=0, `cmd_repeat`=0, `key_held`=0, `overflow`=0.
- Latency: a strobe at cycle n into an empty queue gives `cmd_valid`=1 with data at cycle n+1. `key_held` rises at n+1.
- `cmd_data` and `cmd_repeat` are stable while `cmd_valid`=1 and no ack. After a pop at cycle n, the next entry is presented at n+1.
- Back-to-back acks drain one entry per cycle.
- A release decided at a tick in cycle n gives `key_held`=0 at n+1.
- A reset asserted mid-hold or with a non-empty queue clears everything on the next edge. Queued events are lost.

## Test plan
Bench parameters: TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=5, FIFO_DEPTH=4.
- Single strobe `ir_cmd`=0x45, `cmd_ack` held 1 → one event {0x45, repeat=0} one cycle later; `key_held` falls after 3 ticks (12 clk); no further events.
- Strobe 0x45 repeated every 2 ticks for 12 ticks → one new-press event, then repeat events {0x45,1} at ticks 5 and 10; `key_held` stays 1 until 3 ticks after the last strobe.
- Strobe 0x45 then 0x46 two cycles later → events {0x45,0} then {0x46,0}; `rep_cnt` restarts from 0x46.
- `cmd_ack`=0, five distinct strobes → four queued in order, fifth dropped with one `overflow` pulse; four acks return the first four codes.
- Full queue with strobe and ack in the same cycle → no overflow; the new code lands at the tail.
- `enable`=0 during a hold → `key_held`=0 next cycle; subsequent strobes are ignored; entries already queued still drain.
